fifo_write_arbiter: RTL and testbench

Shares one serial CRC8 engine and one FIFO write port among NREQ byte producers. Each producer raises a request with a byte. The arbiter grants one requester at a time, round-robin, and runs a fixed sequence:
- shift the byte bit-serially into the shared CRC8 engine,
- write it to the FIFO once the FIFO is not busy,
- acknowledge the requester.

It sits between the byte-producing front ends and the shared FIFO/CRC8 pair, and replaces per-producer FIFO access.

---
 rtl/fifo_write_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that lets NREQ byte producers share
// one bit-serial CRC8 engine and one FIFO write port. Each granted byte is
// shifted into the CRC engine LSB first, then written to the FIFO, then the
// requester is acknowledged.
//
// All outputs are registered together with the state, so every output matches
// the state it belongs to. crc_en and fifo_we are also ANDed with enable, so a
// frozen cycle issues no shift and no write. The held state then re-issues
// that bit or write once enable returns.

module fifo_write_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              crc_bit,
  output logic              crc_en,
  input  logic              fifo_busy,
  output logic              fifo_we,
  output logic [7:0]        fifo_din,
  output logic [IDW-1:0]    fifo_src,
  output logic              idle,
  output logic [NREQ-1:0]   proto_err
);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWaitFifo,
    StWrite,
    StAck
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;       // bit of din_q being presented to the CRC
  logic [IDW-1:0]  rr_q, rr_d;         // round-robin search start
  logic [IDW-1:0]  gnt_q, gnt_d;       // granted requester id
  logic [7:0]      din_q, din_d;       // latched byte of the granted requester
  logic            drop_q, drop_d;     // granted requester released req too early

  logic            crc_bit_q, crc_bit_d;
  logic            crc_en_q, crc_en_d;
  logic            fifo_we_q, fifo_we_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] perr_q, perr_d;
  logic            idle_q, idle_d;

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic [7:0]      pick_byte;
  int unsigned     cand;
  logic            req_g;

  // Request level of the currently granted requester.
  assign req_g = req[gnt_q];

  // Round-robin pick: first active request at or after rr_q, wrapping at NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    pick_byte  = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(cand);
        pick_byte  = req_data[8*cand +: 8];
      end
    end
  end

  // State register and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rr_q      <= '0;
      gnt_q     <= '0;
      din_q     <= '0;
      drop_q    <= 1'b0;
      crc_bit_q <= 1'b0;
      crc_en_q  <= 1'b0;
      fifo_we_q <= 1'b0;
      ack_q     <= '0;
      perr_q    <= '0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      din_q     <= din_d;
      drop_q    <= drop_d;
      crc_bit_q <= crc_bit_d;
      crc_en_q  <= crc_en_d;
      fifo_we_q <= fifo_we_d;
      ack_q     <= ack_d;
      perr_q    <= perr_d;
      idle_q    <= idle_d;
    end
  end

  // Next-state logic; enable=0 holds every piece of state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    din_d   = din_q;
    drop_d  = drop_q;
    if (enable) begin
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_d = StShift;
            idx_d   = '0;
            gnt_d   = pick_id;
            din_d   = pick_byte;
            drop_d  = 1'b0;
          end
        end
        StShift: begin
          if (idx_q == 3'd7) begin
            state_d = StWaitFifo;
          end else begin
            idx_d = idx_q + 3'd1;
          end
          if (!req_g) begin
            drop_d = 1'b1;
          end
        end
        StWaitFifo: begin
          if (!fifo_busy) begin
            state_d = StWrite;
          end
          if (!req_g) begin
            drop_d = 1'b1;
          end
        end
        StWrite: begin
          state_d = StAck;
          rr_d    = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
          if (!req_g) begin
            drop_d = 1'b1;
          end
        end
        StAck: begin
          // An early drop spends exactly one cycle here with ack held low.
          if (drop_q || !req_g) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output logic, derived from the upcoming state so outputs align with it.
  always_comb begin
    crc_en_d  = (state_d == StShift);
    crc_bit_d = crc_en_d ? din_d[idx_d] : 1'b0;
    fifo_we_d = (state_d == StWrite);
    idle_d    = (state_d == StIdle);
    ack_d     = '0;
    if ((state_d == StAck) && !drop_d) begin
      ack_d[gnt_d] = 1'b1;
    end
    perr_d = perr_q;
    if (drop_d) begin
      perr_d[gnt_d] = 1'b1;
    end
  end

  assign crc_bit   = crc_bit_q;
  assign crc_en    = crc_en_q & enable;
  assign fifo_we   = fifo_we_q & enable;
  assign fifo_din  = din_q;
  assign fifo_src  = gnt_q;
  assign ack       = ack_q;
  assign idle      = idle_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios push the expected FIFO
// writes and CRC bits into queues; a monitor pops and compares them whenever
// the DUT strobes fifo_we or crc_en.

module tb_fifo_write_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              crc_bit;
  logic              crc_en;
  logic              fifo_busy;
  logic              fifo_we;
  logic [7:0]        fifo_din;
  logic [IDW-1:0]    fifo_src;
  logic              idle;
  logic [NREQ-1:0]   proto_err;

  fifo_write_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .crc_bit   (crc_bit),
    .crc_en    (crc_en),
    .fifo_busy (fifo_busy),
    .fifo_we   (fifo_we),
    .fifo_din  (fifo_din),
    .fifo_src  (fifo_src),
    .idle      (idle),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0    = 0;
  int crc_pulses = 0;

  logic [9:0] wq[$];   // {src, byte}
  logic       cq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_byte(input logic [1:0] src, input logic [7:0] b);
    wq.push_back({src, b});
    for (int i = 0; i < 8; i++) cq.push_back(b[i]);
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 0; i < 8; i++) cq.push_back(b[i]);
  endtask

  task automatic wait_ack(input int g, output int lat);
    int n;
    n = 0;
    while (!ack[g] && n < 60) begin
      tick();
      n++;
    end
    lat = cyc - t0;
  endtask

  // Scoreboard monitor, sampled on the falling edge away from input changes.
  always @(negedge clk) begin
    logic       eb;
    logic [9:0] ew;
    if (crc_en) begin
      crc_pulses++;
      if (cq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL crc_unexpected: got bit %0b, expected no shift", crc_bit);
      end else begin
        eb = cq.pop_front();
        chk("crc_bit", 32'(crc_bit), 32'(eb));
      end
    end
    if (fifo_we) begin
      if (wq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL write_unexpected: got 0x%0h from %0d, expected no write", fifo_din,
                 fifo_src);
      end else begin
        ew = wq.pop_front();
        chk("fifo_din", 32'(fifo_din), 32'(ew[7:0]));
        chk("fifo_src", 32'(fifo_src), 32'(ew[9:8]));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_crc_en"}, 32'(crc_en), 0);
    chk({tag, "_crc_bit"}, 32'(crc_bit), 0);
    chk({tag, "_fifo_we"}, 32'(fifo_we), 0);
    chk({tag, "_fifo_din"}, 32'(fifo_din), 0);
    chk({tag, "_fifo_src"}, 32'(fifo_src), 0);
    chk({tag, "_idle"}, 32'(idle), 1);
    chk({tag, "_proto_err"}, 32'(proto_err), 0);
  endtask

  initial begin
    int lat;
    int n;
    int p0;
    logic saw_ack;

    reset = 1'b1;
    enable = 1'b1;
    req = '0;
    req_data = 32'h13121110;
    fifo_busy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    // Single request, byte 0xA5 from requester 1.
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    t0 = cyc;
    push_byte(2'd1, 8'hA5);
    tick();
    chk("single_crc_en_first", 32'(crc_en), 1);
    chk("single_idle_low", 32'(idle), 0);
    repeat (8) tick();
    chk("single_wait_crc_en", 32'(crc_en), 0);
    tick();
    chk("single_we_at_e10", 32'(fifo_we), 1);
    wait_ack(1, lat);
    chk("single_ack_latency", 32'(lat), 11);
    chk("single_ack", 32'(ack), 32'h2);
    req = '0;
    tick();
    chk("single_ack_fall", 32'(ack), 0);
    chk("single_idle", 32'(idle), 1);

    // Backpressure: busy sampled high for 5 cycles in WAIT_FIFO.
    req_data[31:24] = 8'h3C;
    fifo_busy = 1'b1;
    req = 4'b1000;
    t0 = cyc;
    push_byte(2'd3, 8'h3C);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k >= 9) chk("bp_crc_en_low", 32'(crc_en), 0);
      if (k == 14) chk("bp_no_write_yet", 32'(fifo_we), 0);
    end
    fifo_busy = 1'b0;
    tick();
    chk("bp_we_at_15", 32'(fifo_we), 1);
    wait_ack(3, lat);
    chk("bp_ack_latency", 32'(lat), 16);
    req = '0;
    tick();
    req_data[31:24] = 8'h13;

    // enable=0 for 3 cycles while bit index 4 is presented.
    req_data[7:0] = 8'h6B;
    req = 4'b0001;
    t0 = cyc;
    p0 = crc_pulses;
    push_byte(2'd0, 8'h6B);
    repeat (5) tick();
    enable = 1'b0;
    #1;
    chk("gate_crc_en_low", 32'(crc_en), 0);
    repeat (3) tick();
    enable = 1'b1;
    wait_ack(0, lat);
    chk("gate_ack_latency", 32'(lat), 14);
    chk("gate_crc_pulses", 32'(crc_pulses - p0), 8);
    req = '0;
    tick();
    req_data[7:0] = 8'h10;

    // Early drop of req[2] during SHIFT.
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    t0 = cyc;
    push_byte(2'd2, 8'h5A);
    repeat (3) tick();
    req = '0;
    saw_ack = 1'b0;
    n = 0;
    while (!idle && n < 40) begin
      tick();
      n++;
      if (ack[2]) saw_ack = 1'b1;
    end
    chk("drop_idle_latency", 32'(cyc - t0), 12);
    chk("drop_no_ack", 32'(saw_ack), 0);
    chk("drop_proto_err", 32'(proto_err), 32'h4);
    tick();
    chk("drop_proto_err_sticky", 32'(proto_err), 32'h4);
    req_data[23:16] = 8'h12;

    // Reset while in WAIT_FIFO: no write, everything back to reset values.
    req_data[15:8] = 8'hC3;
    fifo_busy = 1'b1;
    req = 4'b0010;
    push_bits(8'hC3);
    repeat (11) tick();
    chk("rst_mid_waiting", 32'(idle), 0);
    reset = 1'b1;
    req = '0;
    tick();
    chk_reset_vals("rst_mid");
    fifo_busy = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_mid_still_idle", 32'(idle), 1);
    req_data[15:8] = 8'h11;

    // Round robin: all four requesting, each re-raised after its ack.
    push_byte(2'd0, 8'h10);
    push_byte(2'd1, 8'h11);
    push_byte(2'd2, 8'h12);
    push_byte(2'd3, 8'h13);
    push_byte(2'd0, 8'h10);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      t0 = cyc;
      wait_ack(i % 4, lat);
      chk("rr_ack_onehot", 32'(ack), 32'(1) << (i % 4));
      req[i % 4] = 1'b0;
      tick();
      chk("rr_ack_fall", 32'(ack), 0);
      req[i % 4] = 1'b1;
    end
    req = '0;
    repeat (20) tick();

    chk("queue_writes_drained", 32'(wq.size()), 0);
    chk("queue_bits_drained", 32'(cq.size()), 0);
    chk("final_idle", 32'(idle), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
